stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
- Control sequencer in front of the stopwatch digit counter.
- Conditions the raw pause button, ADJ switch and SEL switches.
- Runs a PAUSED/RUN/ADJUST state machine.
- Generates the single-cycle enables that advance the counter: 1 Hz count in RUN, 2 Hz selected-digit increment in ADJUST.
- Generates the blink mask the display driver uses to flash the digit being adjusted.

Parameters:
- DIV_COUNT, 100000000: clock cycles per count_en pulse (1 Hz at 100 MHz).
- DIV_ADJ, 50000000: clock cycles per adj_inc pulse (2 Hz).
- DIV_BLINK, 25000000: clock cycles per blink phase toggle.
- DEB_CYCLES, 1000000: consecutive stable cycles required to accept a new pause-button level.

Ports:
- clk_c  input  1  system clock.
- reset_c  input  1  synchronous, active-high reset.
- pause_btn  input  1  raw, asynchronous, bouncing pause button; high = pressed.
- adj_sw  input  1  raw ADJ switch; 1 = adjust mode.
- sel_sw  input  2  raw digit select: 00 sec ones, 01 sec tens, 10 min ones, 11 min tens.
- count_en  output  1  one-cycle pulse; counter advances one second.
- adj_inc  output  1  one-cycle pulse; counter increments digit adj_sel (wrap handled by counter).
- adj_sel  output  2  synchronized SEL, valid whenever state is ADJUST.
- blink_mask  output  4  bit i = 1 means blank digit i (bit0 sec ones … bit3 min tens).
- state_o  output  2  00 PAUSED, 01 RUN, 10 ADJUST.

Behaviour:
- Clock and reset: one clock, clk_c. reset_c is synchronous and active-high; every register takes its reset value on the first clk_c edge with reset_c=1, including mid-operation.
- Reset values:
  - State PAUSED; count_en=0, adj_inc=0, adj_sel=00, blink_mask=0000, state_o=00.
  - All divider counters 0; blink phase 0.
  - Synchronizers 0; debounced level 0; debounce counter 0.
- Input sync: pause_btn, adj_sw and sel_sw each pass through a 2-flop synchronizer. adj_sel = synchronized sel_sw.
- Debounce:
  - If the synced button equals the debounced level, the debounce counter clears.
  - Otherwise it increments.
  - When the counter reaches DEB_CYCLES-1 while still differing, the debounced level takes the synced value and the counter clears.
  - press_evt = debounced level rising edge, one cycle wide. Release produces no event.
- FSM, evaluated in priority order each cycle:
  1. Synced adj_sw=1 in any state → ADJUST.
  2. ADJUST with synced adj_sw=0 → PAUSED.
  3. PAUSED with press_evt → RUN.
  4. RUN with press_evt → PAUSED.
  5. Otherwise hold.
- FSM notes: press_evt in ADJUST is ignored. press_evt coincident with adj_sw=1 → ADJUST, and the press is consumed. state_o reflects the registered state.
- Count divider:
  - Counts only while state is RUN; held at 0 in every other state.
  - count_en=1 for exactly one cycle when the counter is at DIV_COUNT-1 in RUN; the counter then wraps to 0.
  - First count_en comes DIV_COUNT cycles after the first RUN cycle.
  - Pausing discards the partial second.
- Adjust divider: same structure with DIV_ADJ, active only in ADJUST, output adj_inc. First adj_inc comes DIV_ADJ cycles after entering ADJUST.
- count_en and adj_inc are never high in the same cycle.
- Blink:
  - Free-running divider of DIV_BLINK cycles; blink phase toggles at the wrap.
  - blink_mask = one-hot(adj_sel) when state is ADJUST and phase=1, else 0000.
  - An adj_sel change moves the mask the same cycle.
- Latency, pause press to state change: 2 sync cycles + DEB_CYCLES + 1 (state register). ADJ switch to state change: 3 cycles.

Test Plan:
Bench parameters: DIV_COUNT=10, DIV_ADJ=5, DIV_BLINK=4, DEB_CYCLES=3.
1. Reset, then clean pause press held 10 cycles → state_o 00→01 exactly 2+3+1 cycles after the press; count_en pulses every 10 cycles, first at 10 cycles after entering RUN; adj_inc stays 0.
2. In RUN, pause_btn toggles every cycle for 8 cycles, then settles low → no state change, no press_evt; count_en cadence unbroken. A second clean press → PAUSED; count_en stops; a re-press restarts with the full 10-cycle delay.
3. adj_sw=1 with SEL=10 → state_o=10 after 3 cycles; adj_inc every 5 cycles; blink_mask alternates 0100/0000 every 4 cycles. Change SEL to 11 → mask moves to 1000. Pause press → ignored. adj_sw=0 → PAUSED, blink_mask=0000.
4. Debounced press and adj_sw rise reach the FSM in the same cycle → ADJUST, not RUN. Dropping adj_sw afterwards → PAUSED.
5. reset_c pulsed for 1 cycle mid-RUN and mid-ADJUST → the next cycle shows state_o=00, all outputs 0, and the first count_en after re-run arrives at the full 10-cycle delay.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: input conditioning, PAUSED/RUN/ADJUST FSM,
// count/adjust enable generation and adjust-digit blink mask.
module stopwatch_ctrl #(
  parameter int unsigned DIV_COUNT  = 100000000,
  parameter int unsigned DIV_ADJ    = 50000000,
  parameter int unsigned DIV_BLINK  = 25000000,
  parameter int unsigned DEB_CYCLES = 1000000
) (
  input  logic       clk_c,
  input  logic       reset_c,
  input  logic       pause_btn,
  input  logic       adj_sw,
  input  logic [1:0] sel_sw,
  output logic       count_en,
  output logic       adj_inc,
  output logic [1:0] adj_sel,
  output logic [3:0] blink_mask,
  output logic [1:0] state_o
);

  localparam int unsigned CW = (DIV_COUNT  > 1) ? $clog2(DIV_COUNT)  : 1;
  localparam int unsigned AW = (DIV_ADJ    > 1) ? $clog2(DIV_ADJ)    : 1;
  localparam int unsigned BW = (DIV_BLINK  > 1) ? $clog2(DIV_BLINK)  : 1;
  localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_PAUSED = 2'b00,
    ST_RUN    = 2'b01,
    ST_ADJUST = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic            pb_s1_q, pb_s2_q, adj_s1_q, adj_s2_q;
  logic [1:0]      sel_s1_q, sel_s2_q;
  logic            deb_q, deb_d, deb_prev_q;
  logic [DW-1:0]   deb_cnt_q, deb_cnt_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   adj_cnt_q, adj_cnt_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            phase_q, phase_d;
  logic            count_en_q, count_en_d;
  logic            adj_inc_q, adj_inc_d;
  logic            press_evt;

  assign press_evt = deb_q & ~deb_prev_q;

  // State register
  always_ff @(posedge clk_c) begin
    if (reset_c) state_q <= ST_PAUSED;
    else         state_q <= state_d;
  end

  // Next state: the ADJ switch overrides everything, presses only toggle PAUSED/RUN
  always_comb begin
    state_d = state_q;
    if (adj_s2_q) begin
      state_d = ST_ADJUST;
    end else begin
      case (state_q)
        ST_ADJUST: state_d = ST_PAUSED;
        ST_PAUSED: if (press_evt) state_d = ST_RUN;
        ST_RUN:    if (press_evt) state_d = ST_PAUSED;
        default:   state_d = ST_PAUSED;
      endcase
    end
  end

  // Debounce, dividers and blink phase
  always_comb begin
    deb_d       = deb_q;
    deb_cnt_d   = '0;
    cnt_d       = '0;
    count_en_d  = 1'b0;
    adj_cnt_d   = '0;
    adj_inc_d   = 1'b0;
    blink_cnt_d = blink_cnt_q + BW'(1);
    phase_d     = phase_q;

    if (pb_s2_q != deb_q) begin
      if (deb_cnt_q == DW'(DEB_CYCLES - 1)) deb_d = pb_s2_q;
      else                                  deb_cnt_d = deb_cnt_q + DW'(1);
    end

    if (state_q == ST_RUN) begin
      if (cnt_q == CW'(DIV_COUNT - 1)) count_en_d = 1'b1;
      else                             cnt_d = cnt_q + CW'(1);
    end

    if (state_q == ST_ADJUST) begin
      if (adj_cnt_q == AW'(DIV_ADJ - 1)) adj_inc_d = 1'b1;
      else                               adj_cnt_d = adj_cnt_q + AW'(1);
    end

    if (blink_cnt_q == BW'(DIV_BLINK - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

  // Synchronizers and datapath registers
  always_ff @(posedge clk_c) begin
    if (reset_c) begin
      pb_s1_q     <= 1'b0;
      pb_s2_q     <= 1'b0;
      adj_s1_q    <= 1'b0;
      adj_s2_q    <= 1'b0;
      sel_s1_q    <= 2'b00;
      sel_s2_q    <= 2'b00;
      deb_q       <= 1'b0;
      deb_prev_q  <= 1'b0;
      deb_cnt_q   <= '0;
      cnt_q       <= '0;
      adj_cnt_q   <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      count_en_q  <= 1'b0;
      adj_inc_q   <= 1'b0;
    end else begin
      pb_s1_q     <= pause_btn;
      pb_s2_q     <= pb_s1_q;
      adj_s1_q    <= adj_sw;
      adj_s2_q    <= adj_s1_q;
      sel_s1_q    <= sel_sw;
      sel_s2_q    <= sel_s1_q;
      deb_q       <= deb_d;
      deb_prev_q  <= deb_q;
      deb_cnt_q   <= deb_cnt_d;
      cnt_q       <= cnt_d;
      adj_cnt_q   <= adj_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      count_en_q  <= count_en_d;
      adj_inc_q   <= adj_inc_d;
    end
  end

  // Mask follows the synchronized select directly so a SEL change moves it at once
  assign blink_mask = (state_q == ST_ADJUST && phase_q) ? 4'(4'b0001 << sel_s2_q) : 4'b0000;
  assign count_en   = count_en_q;
  assign adj_inc    = adj_inc_q;
  assign adj_sel    = sel_s2_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: directed scenarios plus random stimulus
// against a cycle-level behavioural model built from run lengths and modular arithmetic.
module tb_stopwatch_ctrl;

  localparam int unsigned DIV_COUNT  = 10;
  localparam int unsigned DIV_ADJ    = 5;
  localparam int unsigned DIV_BLINK  = 4;
  localparam int unsigned DEB_CYCLES = 3;

  logic       clk_c = 1'b0;
  logic       reset_c, pause_btn, adj_sw;
  logic [1:0] sel_sw;
  logic       count_en, adj_inc;
  logic [1:0] adj_sel, state_o;
  logic [3:0] blink_mask;

  always #5 clk_c = ~clk_c;

  stopwatch_ctrl #(
    .DIV_COUNT (DIV_COUNT),
    .DIV_ADJ   (DIV_ADJ),
    .DIV_BLINK (DIV_BLINK),
    .DEB_CYCLES(DEB_CYCLES)
  ) dut (
    .clk_c     (clk_c),
    .reset_c   (reset_c),
    .pause_btn (pause_btn),
    .adj_sw    (adj_sw),
    .sel_sw    (sel_sw),
    .count_en  (count_en),
    .adj_inc   (adj_inc),
    .adj_sel   (adj_sel),
    .blink_mask(blink_mask),
    .state_o   (state_o)
  );

  typedef struct packed {
    logic       count_en;
    logic       adj_inc;
    logic [1:0] adj_sel;
    logic [3:0] blink_mask;
    logic [1:0] state;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: 0 PAUSED, 1 RUN, 2 ADJUST; st_len = cycles spent in current state
  int unsigned m_t, m_st, m_len, m_differ;
  bit          m_pb[2], m_adj[2];
  bit [1:0]    m_sel[2];
  bit          m_deb, m_deb_prev, m_cen, m_ainc;

  task automatic model_step(input bit r, input bit pb, input bit adj, input bit [1:0] sel);
    exp_t        e;
    int unsigned nst;
    bit          press;
    if (r) begin
      m_t = 0; m_st = 0; m_len = 1; m_differ = 0;
      m_pb  = '{0, 0}; m_adj = '{0, 0}; m_sel = '{2'b00, 2'b00};
      m_deb = 0; m_deb_prev = 0; m_cen = 0; m_ainc = 0;
    end else begin
      press = m_deb && !m_deb_prev;
      if (m_adj[1])     nst = 2;
      else if (m_st == 2) nst = 0;
      else if (press)   nst = (m_st == 0) ? 1 : 0;
      else              nst = m_st;
      m_cen  = (m_st == 1) && (m_len % DIV_COUNT == 0);
      m_ainc = (m_st == 2) && (m_len % DIV_ADJ == 0);
      m_deb_prev = m_deb;
      if (m_pb[1] == m_deb) m_differ = 0;
      else begin
        m_differ++;
        if (m_differ == DEB_CYCLES) begin
          m_deb    = m_pb[1];
          m_differ = 0;
        end
      end
      m_pb[1] = m_pb[0];   m_pb[0] = pb;
      m_adj[1] = m_adj[0]; m_adj[0] = adj;
      m_sel[1] = m_sel[0]; m_sel[0] = sel;
      m_len = (nst == m_st) ? m_len + 1 : 1;
      m_st  = nst;
      m_t++;
    end
    e.count_en   = m_cen;
    e.adj_inc    = m_ainc;
    e.adj_sel    = m_sel[1];
    e.blink_mask = (m_st == 2 && ((m_t / DIV_BLINK) % 2) == 1) ? (4'b0001 << m_sel[1]) : 4'b0000;
    e.state      = 2'(m_st);
    exp_q.push_back(e);
  endtask

  // Hold one input pattern for n clock edges, predicting each resulting cycle
  task automatic go(input bit r, input bit pb, input bit adj, input bit [1:0] sel, input int n);
    for (int i = 0; i < n; i++) begin
      reset_c   = r;
      pause_btn = pb;
      adj_sw    = adj;
      sel_sw    = sel;
      @(posedge clk_c);
      model_step(r, pb, adj, sel);
      #1;
    end
  endtask

  // Monitor: compare every presented cycle against the oldest prediction
  initial begin : monitor
    exp_t e, got;
    forever begin
      @(negedge clk_c);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {count_en, adj_inc, adj_sel, blink_mask, state_o};
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL outputs vec %0d t=%0t: got cen=%b ainc=%b sel=%b mask=%b st=%b, want cen=%b ainc=%b sel=%b mask=%b st=%b",
                   vectors, $time, got.count_en, got.adj_inc, got.adj_sel, got.blink_mask, got.state,
                   e.count_en, e.adj_inc, e.adj_sel, e.blink_mask, e.state);
        end
      end
    end
  end

  initial begin : stimulus
    bit       adj_r;
    bit [1:0] sel_r;
    reset_c = 1'b1; pause_btn = 1'b0; adj_sw = 1'b0; sel_sw = 2'b00;
    // Reset then a clean press into RUN
    go(1, 0, 0, 0, 2);
    go(0, 0, 0, 0, 3);
    go(0, 1, 0, 0, 10);
    go(0, 0, 0, 0, 25);
    // Bouncing button in RUN, then clean presses to pause and resume
    for (int i = 0; i < 8; i++) go(0, (i % 2) == 0, 0, 0, 1);
    go(0, 0, 0, 0, 15);
    go(0, 1, 0, 0, 8);
    go(0, 0, 0, 0, 20);
    go(0, 1, 0, 0, 8);
    go(0, 0, 0, 0, 30);
    // Adjust mode: select change, ignored press, exit to PAUSED
    go(0, 0, 1, 2, 25);
    go(0, 0, 1, 3, 12);
    go(0, 1, 1, 3, 8);
    go(0, 0, 1, 3, 5);
    go(0, 0, 0, 3, 10);
    // Debounced press and synced ADJ rise land on the same cycle
    go(0, 1, 0, 1, 3);
    go(0, 1, 1, 1, 8);
    go(0, 0, 1, 1, 4);
    go(0, 0, 0, 1, 8);
    // Reset pulses mid-RUN and mid-ADJUST
    go(0, 1, 0, 0, 8);
    go(0, 0, 0, 0, 7);
    go(1, 0, 0, 0, 1);
    go(0, 1, 0, 0, 8);
    go(0, 0, 0, 0, 20);
    go(0, 0, 1, 1, 10);
    go(1, 0, 1, 1, 1);
    go(0, 0, 1, 1, 12);
    go(0, 0, 0, 1, 6);
    // Random segments
    adj_r = 1'b0;
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 5) == 0) adj_r = ~adj_r;
      sel_r = 2'($urandom_range(0, 3));
      go($urandom_range(0, 79) == 0, 1'($urandom_range(0, 1)), adj_r, sel_r,
         int'($urandom_range(1, 12)));
    end
    go(0, 0, 0, 0, 2);
    @(negedge clk_c);
    @(negedge clk_c);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d predictions left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
